// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared constants and types for the register-file
// writeback arbiter and its busy scoreboard.
//   XLEN                 - default data width
//   REG_ADDR_W           - register address width
//   NUM_REGS             - number of architectural registers
//   STARVE_LIMIT_DEFAULT - default stalled-cycle budget for requester 1
//   arb_state_e          - arbiter state (NORMAL / FORCE1)
package regfile_ctrl_pkg;

    localparam int unsigned XLEN                 = 64;
    localparam int unsigned REG_ADDR_W           = 5;
    localparam int unsigned NUM_REGS             = 32;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } arb_state_e;

endpackage : regfile_ctrl_pkg

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-destination busy vector.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   set_valid / set_rd    - mark set_rd pending at the edge (x0 ignored)
//   clr_valid / clr_rd    - release clr_rd at the edge
//   q1_rd / q1_busy_c     - combinational hazard query 1
//   q2_rd / q2_busy_c     - combinational hazard query 2
// A set and a clear on the same register in the same cycle leaves it busy.
module wb_scoreboard
    import regfile_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] q1_rd,
    output logic                  q1_busy_c,
    input  logic [REG_ADDR_W-1:0] q2_rd,
    output logic                  q2_busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first, then set, so a same-edge set overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_valid && (set_rd != '0)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Queries read the registered vector; x0 is never busy.
    always_comb begin
        q1_busy_c = (q1_rd != '0) && busy_q[q1_rd];
        q2_busy_c = (q2_rd != '0) && busy_q[q2_rd];
    end

endmodule : wb_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-port writeback arbiter in front of the register
// file write port, with a starvation guard for the multi-cycle port and a
// busy scoreboard for hazard queries.
// Parameters:
//   XLEN         - data width
//   STARVE_LIMIT - stalled cycles of requester 1 before it is forced through
// Ports:
//   clk, reset_n                          - clock, async active-low reset
//   req0_valid/ready/rd/data              - ALU writeback (normal priority)
//   req1_valid/ready/rd/data              - load/mul writeback
//   issue_valid / issue_rd                - mark a destination pending
//   rs1, rs2 / rs1_busy, rs2_busy         - hazard queries (combinational)
//   rf_reg_write / rf_rd / rf_write_data  - registered register-file write
// Build option REGFILE_WB_BYPASS_EN adds byp1_hit/byp1_data and
// byp2_hit/byp2_data, forwarding the commit-cycle value and masking the
// corresponding busy indication.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN         = regfile_ctrl_pkg::XLEN,
    parameter int unsigned STARVE_LIMIT = regfile_ctrl_pkg::STARVE_LIMIT_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    req0_valid,
    output logic                                    req0_ready,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] req0_rd,
    input  logic [XLEN-1:0]                         req0_data,
    input  logic                                    req1_valid,
    output logic                                    req1_ready,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] req1_rd,
    input  logic [XLEN-1:0]                         req1_data,
    input  logic                                    issue_valid,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] issue_rd,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] rs1,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] rs2,
    output logic                                    rs1_busy,
    output logic                                    rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                                    byp1_hit,
    output logic [XLEN-1:0]                         byp1_data,
    output logic                                    byp2_hit,
    output logic [XLEN-1:0]                         byp2_data,
`endif
    output logic                                    rf_reg_write,
    output logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]                         rf_write_data
);

    import regfile_ctrl_pkg::*;

    localparam int unsigned CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e             state_q;
    arb_state_e             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   rf_reg_write_q;
    logic                   rf_reg_write_d;
    logic [REG_ADDR_W-1:0]  rf_rd_q;
    logic [REG_ADDR_W-1:0]  rf_rd_d;
    logic [XLEN-1:0]        rf_write_data_q;
    logic [XLEN-1:0]        rf_write_data_d;

    logic                   xfer0;
    logic                   xfer1;
    logic                   sb_rs1_busy_c;
    logic                   sb_rs2_busy_c;

    // Each ready looks only at the other port's valid, so a port is never
    // gated by its own request; the two readies are mutually exclusive
    // whenever both ports are valid.
    always_comb begin
        req0_ready = 1'b1;
        req1_ready = 1'b0;
        if (state_q == FORCE1) begin
            req1_ready = 1'b1;
            req0_ready = !req1_valid;
        end else begin
            req0_ready = 1'b1;
            req1_ready = !req0_valid;
        end
    end

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    // Starvation counter and arbiter next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!req1_valid || xfer1) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            NORMAL: begin
                if (req1_valid && !req1_ready && (cnt_q == CNT_MAX)) begin
                    state_d = FORCE1;
                end
            end
            FORCE1: begin
                if (xfer1 || !req1_valid) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // Commit payload for the next cycle; an x0 destination is accepted but
    // never raises the write strobe.
    always_comb begin
        rf_reg_write_d  = 1'b0;
        rf_rd_d         = '0;
        rf_write_data_d = '0;
        if (xfer0) begin
            rf_reg_write_d  = (req0_rd != '0);
            rf_rd_d         = req0_rd;
            rf_write_data_d = req0_data;
        end else if (xfer1) begin
            rf_reg_write_d  = (req1_rd != '0);
            rf_rd_d         = req1_rd;
            rf_write_data_d = req1_data;
        end
    end

    // Arbiter state, starvation counter and commit register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= NORMAL;
            cnt_q           <= '0;
            rf_reg_write_q  <= 1'b0;
            rf_rd_q         <= '0;
            rf_write_data_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rf_reg_write_q  <= rf_reg_write_d;
            rf_rd_q         <= rf_rd_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    assign rf_reg_write  = rf_reg_write_q;
    assign rf_rd         = rf_rd_q;
    assign rf_write_data = rf_write_data_q;

    // Pending destinations: set on issue, released by the commit cycle.
    wb_scoreboard u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_valid (issue_valid),
        .set_rd    (issue_rd),
        .clr_valid (rf_reg_write_q),
        .clr_rd    (rf_rd_q),
        .q1_rd     (rs1),
        .q1_busy_c (sb_rs1_busy_c),
        .q2_rd     (rs2),
        .q2_busy_c (sb_rs2_busy_c)
    );

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the value being committed this cycle to matching readers.
    assign byp1_hit  = rf_reg_write_q && (rf_rd_q == rs1) && (rs1 != '0);
    assign byp2_hit  = rf_reg_write_q && (rf_rd_q == rs2) && (rs2 != '0);
    assign byp1_data = rf_write_data_q;
    assign byp2_data = rf_write_data_q;
    assign rs1_busy  = sb_rs1_busy_c && !byp1_hit;
    assign rs2_busy  = sb_rs2_busy_c && !byp2_hit;
`else
    // Without forwarding a register stays busy through its commit cycle.
    assign rs1_busy  = sb_rs1_busy_c;
    assign rs2_busy  = sb_rs2_busy_c;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed table, hand-written corner sequences and a
// randomized run against a reference model of the writeback arbiter.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned LIMIT = 4;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic            clk;
    logic            reset_n;
    logic            req0_valid;
    logic            req0_ready;
    logic [4:0]      req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req1_valid;
    logic            req1_ready;
    logic [4:0]      req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
`ifdef REGFILE_WB_BYPASS_EN
    logic            byp1_hit;
    logic [XLEN-1:0] byp1_data;
    logic            byp2_hit;
    logic [XLEN-1:0] byp2_data;
`endif
    logic            rf_reg_write;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_write_data;

    int unsigned n_total;
    int unsigned n_pass;

    regfile_wb_arbiter #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_rd       (req0_rd),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_rd       (req1_rd),
        .req1_data     (req1_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
`ifdef REGFILE_WB_BYPASS_EN
        .byp1_hit      (byp1_hit),
        .byp1_data     (byp1_data),
        .byp2_hit      (byp2_hit),
        .byp2_data     (byp2_data),
`endif
        .rf_reg_write  (rf_reg_write),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  rd0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [63:0] d1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        e_r0;
        logic        e_r1;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [63:0] e_data;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    // Reference-model state for the randomized phase.
    bit [31:0]   busy_m;
    int unsigned run_m;
    bit          m_we;
    bit [4:0]    m_rd;
    bit [63:0]   m_data;
    bit          p0, p1;
    bit [4:0]    p0_rd, p1_rd;
    bit [63:0]   p0_data, p1_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [63:0] d1,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] q1, input logic [4:0] q2);
        req0_valid  = v0;
        req0_rd     = rd0;
        req0_data   = d0;
        req1_valid  = v1;
        req1_rd     = rd1;
        req1_data   = d1;
        issue_valid = iv;
        issue_rd    = ird;
        rs1         = q1;
        rs2         = q2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_commit(input string tag, input logic [4:0] erd, input logic [63:0] edata);
        check({tag, "_we"}, 64'(rf_reg_write), 64'h1);
        check({tag, "_rd"}, 64'(rf_rd), 64'(erd));
        check({tag, "_data"}, rf_write_data, edata);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t tbl[6];

        n_total = 0;
        n_pass  = 0;

        // Priority, x0 and issue/query rows, starting from a fresh reset.
        tbl[0] = '{1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22, 1'b0, 5'd0, 5'd3, 5'd4,
                   1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 64'h22, 1'b0, 5'd0, 5'd3, 5'd4,
                   1'b1, 1'b1, 1'b1, 5'd3, 64'h11, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                   1'b1, 1'b0, 1'b1, 5'd4, 64'h22, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0,
                   1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd0, 5'd7,
                   1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                   1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0};

        // Reset state.
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", 64'(rf_reg_write), 64'h0);
        check("rst_rd", 64'(rf_rd), 64'h0);
        check("rst_data", rf_write_data, 64'h0);
        check("rst_r0", 64'(req0_ready), 64'h1);
        check("rst_r1", 64'(req1_ready), 64'h1);
        step();
        reset_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1,
                  tbl[i].iv, tbl[i].ird, tbl[i].q1, tbl[i].q2);
            @(negedge clk);
            check($sformatf("tbl%0d_r0", i), 64'(req0_ready), 64'(tbl[i].e_r0));
            check($sformatf("tbl%0d_r1", i), 64'(req1_ready), 64'(tbl[i].e_r1));
            check($sformatf("tbl%0d_we", i), 64'(rf_reg_write), 64'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_rd", i), 64'(rf_rd), 64'(tbl[i].e_rd));
                check($sformatf("tbl%0d_data", i), rf_write_data, tbl[i].e_data);
            end
            check($sformatf("tbl%0d_b1", i), 64'(rs1_busy), 64'(tbl[i].e_b1));
            check($sformatf("tbl%0d_b2", i), 64'(rs2_busy), 64'(tbl[i].e_b2));
            step();
        end

        // Scoreboard release by a req1 commit of x7 (x7 busy from the table).
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 5'd7, 5'd0);
        @(negedge clk);
        check("sb_r1", 64'(req1_ready), 64'h1);
        check("sb_busy_before", 64'(rs1_busy), 64'h1);
        step();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        @(negedge clk);
        check_commit("sb_commit", 5'd7, 64'h77);
        check("sb_busy_commit", 64'(rs1_busy), 64'(!BYP_EN));
        step();
        @(negedge clk);
        check("sb_busy_after", 64'(rs1_busy), 64'h0);
        step();

        // Same-edge issue and commit of x7: set wins.
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h78, 1'b1, 5'd7, 5'd7, 5'd0);
        step();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd7, 5'd0);
        @(negedge clk);
        check_commit("sw_commit", 5'd7, 64'h78);
        step();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        @(negedge clk);
        check("sw_busy_kept", 64'(rs1_busy), 64'h1);
        step();

        // Commit-cycle query of x9, forwarding when built in.
        drive(1'b1, 5'd9, 64'h1234, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        @(negedge clk);
        check_commit("byp_commit", 5'd9, 64'h1234);
        check("byp_rs2_busy", 64'(rs2_busy), 64'(!BYP_EN));
`ifdef REGFILE_WB_BYPASS_EN
        check("byp2_hit", 64'(byp2_hit), 64'h1);
        check("byp2_data", byp2_data, 64'h1234);
        check("byp1_hit", 64'(byp1_hit), 64'h0);
`endif
        step();
        @(negedge clk);
        check("byp_rs2_after", 64'(rs2_busy), 64'h0);
        step();
        idle();
        step();

        // Starvation: req0 always valid, req1 forced through after LIMIT+1 stalls.
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 5'd1, 64'(256 + c), 1'b1, 5'd2, 64'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
            @(negedge clk);
            check($sformatf("starve%0d_r0", c), 64'(req0_ready), 64'h1);
            check($sformatf("starve%0d_r1", c), 64'(req1_ready), 64'h0);
            if (c > 0) begin
                check_commit($sformatf("starve%0d", c), 5'd1, 64'(256 + c - 1));
            end else begin
                check("starve0_we", 64'(rf_reg_write), 64'h0);
            end
            step();
        end
        drive(1'b1, 5'd1, 64'h105, 1'b1, 5'd2, 64'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("starve5_r1", 64'(req1_ready), 64'h1);
        check("starve5_r0", 64'(req0_ready), 64'h0);
        check_commit("starve5", 5'd1, 64'h104);
        step();
        drive(1'b1, 5'd1, 64'h105, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check_commit("starve6", 5'd2, 64'hBEEF);
        check("starve6_r0", 64'(req0_ready), 64'h1);
        step();
        idle();
        @(negedge clk);
        check_commit("starve7", 5'd1, 64'h105);
        step();

        // Reset asserted mid-transfer: nothing commits, busy cleared.
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd12, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd12);
        @(negedge clk);
        check("rm_busy5", 64'(rs1_busy), 64'h1);
        check("rm_busy12", 64'(rs2_busy), 64'h1);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("rm_we_in_rst", 64'(rf_reg_write), 64'h0);
        check("rm_r0_in_rst", 64'(req0_ready), 64'h1);
        check("rm_r1_in_rst", 64'(req1_ready), 64'h0);
        check("rm_busy_in_rst", 64'(rs1_busy), 64'h0);
        step();
        reset_n = 1'b1;
        idle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rm_we_after%0d", c), 64'(rf_reg_write), 64'h0);
            step();
        end
        for (int r = 0; r < 16; r++) begin
            drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'(r), 5'(r + 16));
            @(negedge clk);
            check($sformatf("rm_busy_x%0d", r), 64'(rs1_busy), 64'h0);
            check($sformatf("rm_busy_x%0d", r + 16), 64'(rs2_busy), 64'h0);
            step();
        end

        // Randomized traffic against the reference model.
        do_reset();
        busy_m = '0;
        run_m  = 0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        p0     = 1'b0;
        p1     = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit       forced, e_r0, e_r1, x0, x1, iv, e_b1, e_b2;
            bit [4:0] ird, q1, q2;

            if (!p0 && ($urandom_range(0, 3) != 0)) begin
                p0      = 1'b1;
                p0_rd   = 5'($urandom_range(0, 31));
                p0_data = {$urandom, $urandom};
            end
            if (!p1 && ($urandom_range(0, 1) != 0)) begin
                p1      = 1'b1;
                p1_rd   = 5'($urandom_range(0, 31));
                p1_data = {$urandom, $urandom};
            end
            iv  = ($urandom_range(0, 2) == 0);
            ird = 5'($urandom_range(0, 31));
            q1  = ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom_range(0, 31));
            q2  = ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom_range(0, 31));
            drive(p0, p0_rd, p0_data, p1, p1_rd, p1_data, iv, ird, q1, q2);

            // Requester 1 jumps the queue after LIMIT+1 consecutive stalls.
            forced = (run_m >= LIMIT + 1);
            e_r0   = forced ? !p1 : 1'b1;
            e_r1   = forced ? 1'b1 : !p0;
            x0     = p0 && e_r0;
            x1     = p1 && e_r1;
            e_b1   = (q1 != 0) && busy_m[q1] && !(BYP_EN && m_we && (m_rd == q1));
            e_b2   = (q2 != 0) && busy_m[q2] && !(BYP_EN && m_we && (m_rd == q2));

            @(negedge clk);
            check($sformatf("rnd%0d_r0", cyc), 64'(req0_ready), 64'(e_r0));
            check($sformatf("rnd%0d_r1", cyc), 64'(req1_ready), 64'(e_r1));
            check($sformatf("rnd%0d_xfers", cyc),
                  64'(int'(req0_valid && req0_ready) + int'(req1_valid && req1_ready)),
                  64'(int'(x0) + int'(x1)));
            check($sformatf("rnd%0d_we", cyc), 64'(rf_reg_write), 64'(m_we));
            if (m_we) begin
                check($sformatf("rnd%0d_rd", cyc), 64'(rf_rd), 64'(m_rd));
                check($sformatf("rnd%0d_data", cyc), rf_write_data, m_data);
            end
            check($sformatf("rnd%0d_b1", cyc), 64'(rs1_busy), 64'(e_b1));
            check($sformatf("rnd%0d_b2", cyc), 64'(rs2_busy), 64'(e_b2));
`ifdef REGFILE_WB_BYPASS_EN
            check($sformatf("rnd%0d_h1", cyc), 64'(byp1_hit), 64'(m_we && (m_rd == q1) && (q1 != 0)));
            check($sformatf("rnd%0d_h2", cyc), 64'(byp2_hit), 64'(m_we && (m_rd == q2) && (q2 != 0)));
`endif

            // Advance the model across the clock edge.
            run_m = (p1 && !e_r1) ? run_m + 1 : 0;
            if (m_we) begin
                busy_m[m_rd] = 1'b0;
            end
            if (iv && (ird != 0)) begin
                busy_m[ird] = 1'b1;
            end
            if (x0) begin
                m_we   = (p0_rd != 0);
                m_rd   = p0_rd;
                m_data = p0_data;
                p0     = 1'b0;
            end else if (x1) begin
                m_we   = (p1_rd != 0);
                m_rd   = p1_rd;
                m_data = p1_data;
                p1     = 1'b0;
            end else begin
                m_we   = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
